// File: rtl/mem_stage_store_buffer.sv
// MEM-stage data-memory responder: stores are posted to an in-order store buffer and retired to a
// word RAM when the port is free; loads read the RAM combinationally and stall while their word is still buffered.
module mem_stage_store_buffer #(
    parameter int SB_DEPTH  = 4,
    parameter int ADDR_BITS = 10
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            MemRead,
    input  logic                            MemWrite,
    input  logic [1:0]                      SEMCtrl,
    input  logic [31:0]                     Address,
    input  logic [31:0]                     WriteData,
    output logic [31:0]                     ReadData,
    output logic                            Stall,
    output logic                            SB_Empty,
    output logic [$clog2(SB_DEPTH+1)-1:0]   SB_Count
);

    localparam int PW        = $clog2(SB_DEPTH);
    localparam int CW        = $clog2(SB_DEPTH + 1);
    localparam int RAM_WORDS = 2 ** ADDR_BITS;
    localparam logic [CW-1:0] DEPTH_C = CW'(SB_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
    localparam logic [PW-1:0] PTR1_C  = PW'(1'b1);

    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b01:   store_be = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   store_be = 4'b0001 << lane;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b01:   store_data = {2{wd[15:0]}};
            2'b10:   store_data = {4{wd[7:0]}};
            default: store_data = wd;
        endcase
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        merge_bytes = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merge_bytes[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                merge_bytes[8*b +: 8] = old_w[8*b +: 8];
            end
        end
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] sz, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = word[8*lane +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b01:   load_extend = {{16{half_v[15]}}, half_v};
            2'b10:   load_extend = {{24{byte_v[7]}}, byte_v};
            default: load_extend = word;
        endcase
    endfunction

    logic [ADDR_BITS-1:0] idx_q   [SB_DEPTH];
    logic [3:0]           be_q    [SB_DEPTH];
    logic [31:0]          data_q  [SB_DEPTH];
    logic [SB_DEPTH-1:0]  valid_q;
    logic [PW-1:0]        head_q;
    logic [PW-1:0]        tail_q;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic                 empty_q;
    logic [31:0]          mem_q   [RAM_WORDS];

    logic [ADDR_BITS-1:0] word_idx_s;
    logic                 hit_s;
    logic                 full_s;
    logic                 drain_s;
    logic                 push_s;
    logic                 load_ok_s;
    logic                 addr_unused_s;

    assign word_idx_s    = Address[ADDR_BITS+1:2];
    assign addr_unused_s = ^Address[31:ADDR_BITS+2];

    // Store-buffer hit detection against every valid entry.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            hit_s = hit_s | (valid_q[i] & (idx_q[i] == word_idx_s));
        end
        hit_s = hit_s & MemRead & ~MemWrite;
    end

    // Port arbitration: a completing load owns the RAM; otherwise the head entry may retire.
    always_comb begin
        full_s    = (count_q == DEPTH_C);
        push_s    = MemWrite;
        load_ok_s = MemRead & ~MemWrite & ~hit_s;
        drain_s   = (count_q != {CW{1'b0}}) &
                    ((~MemRead & ~MemWrite) | hit_s | (MemWrite & full_s));
    end

    // Occupancy next state; a simultaneous push and drain only happens when full.
    always_comb begin
        case ({push_s, drain_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Load response and stall.
    always_comb begin
        Stall = hit_s;
        if (load_ok_s) begin
            ReadData = load_extend(SEMCtrl, Address[1:0], mem_q[word_idx_s]);
        end else begin
            ReadData = 32'h0000_0000;
        end
    end

    // Buffer control state: pointers, valid bits and registered status.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            valid_q <= {SB_DEPTH{1'b0}};
            empty_q <= 1'b1;
        end else begin
            // When full the drained head and pushed tail are the same slot, so push is applied last.
            if (drain_s) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR1_C;
            end
            if (push_s) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR1_C;
            end
            count_q <= count_d;
            empty_q <= (count_d == {CW{1'b0}});
        end
    end

    // Entry payload capture; validity is tracked separately so no reset is needed.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            idx_q[tail_q]  <= word_idx_s;
            be_q[tail_q]   <= store_be(SEMCtrl, Address[1:0]);
            data_q[tail_q] <= store_data(SEMCtrl, WriteData);
        end
    end

    // Word RAM retire port; buffered stores are discarded rather than written during reset.
    always_ff @(posedge Clk) begin
        if (drain_s && !Rst) begin
            mem_q[idx_q[head_q]] <= merge_bytes(mem_q[idx_q[head_q]], data_q[head_q], be_q[head_q]);
        end
    end

    assign SB_Empty = empty_q;
    assign SB_Count = count_q;

endmodule
